// File: rtl/switch_sequencer_if.sv
// -----------------------------------------------------------------------------
// switch_sequencer_if
// Host-side bundle for the photonic switch sequencer.
//   start       host -> seq   request to begin a sequence
//   stop        host -> seq   abort the running sequence
//   ch_mask     host -> seq   channels included in the sweep
//   dwell       host -> seq   idle cycles between pulses (0 behaves as 1)
//   repeats     host -> seq   number of full sweeps, 0 = run until stopped
//   toggle_en   seq -> rx     one-hot single-cycle toggle pulse
//   active_ch   seq -> host   channel currently owning the schedule
//   sweep_count seq -> host   completed sweeps (wraps)
//   busy        seq -> host   sequence in progress
//   done        seq -> host   single-cycle end-of-sequence pulse
// -----------------------------------------------------------------------------
interface switch_sequencer_if #(
   parameter int N_CH     = 4,
   parameter int DWELL_W  = 16,
   parameter int REPEAT_W = 8
);
   localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic                start;
   logic                stop;
   logic [N_CH-1:0]     ch_mask;
   logic [DWELL_W-1:0]  dwell;
   logic [REPEAT_W-1:0] repeats;
   logic [N_CH-1:0]     toggle_en;
   logic [AW-1:0]       active_ch;
   logic [REPEAT_W-1:0] sweep_count;
   logic                busy;
   logic                done;

   // Host / configuration side.
   modport master (
      output start, stop, ch_mask, dwell, repeats,
      input  toggle_en, active_ch, sweep_count, busy, done
   );

   // Sequencer side.
   modport slave (
      input  start, stop, ch_mask, dwell, repeats,
      output toggle_en, active_ch, sweep_count, busy, done
   );
endinterface

// File: rtl/switch_sequencer.sv
// -----------------------------------------------------------------------------
// switch_sequencer
// Issues round-robin single-cycle toggle pulses to a bank of N_CH receiver
// channels, lowest enabled index first, separated by a programmable dwell.
// Runs a programmed number of full sweeps or until stopped.
// Ports:
//   clk    core clock
//   reset  synchronous, active-high
//   bus    switch_sequencer_if.slave (config in, pulses/status out)
// -----------------------------------------------------------------------------
module switch_sequencer #(
   parameter int N_CH     = 4,
   parameter int DWELL_W  = 16,
   parameter int REPEAT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   switch_sequencer_if.slave    bus
);
   localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [1:0] {IDLE, FIRE, DWELL, DONE} state_t;

   state_t              state, state_n;
   logic [N_CH-1:0]     mask_q;
   logic [DWELL_W-1:0]  dwell_q;
   logic [DWELL_W-1:0]  dwell_cnt;
   logic [REPEAT_W-1:0] repeats_q;
   logic [REPEAT_W-1:0] sweep_q;
   logic [REPEAT_W-1:0] sweep_inc;
   logic [AW-1:0]       active_q;
   logic [AW-1:0]       first_ch;
   logic [AW-1:0]       next_ch;
   logic                wrap;
   logic                sweep_end;
   logic                start_ok;

   assign start_ok  = bus.start && (bus.ch_mask != '0);
   assign sweep_inc = sweep_q + REPEAT_W'(1);
   assign sweep_end = wrap && (repeats_q != '0) && (sweep_inc == repeats_q);

   // Lowest set bit of the incoming mask: first channel of a new sequence.
   always_comb begin
      first_ch = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (bus.ch_mask[i]) first_ch = AW'(i);
      end
   end

   // Next channel after active_q in the latched mask. The descending scan
   // leaves the lowest bit above active_q, or the lowest bit overall when
   // none is above; the latter is a wrap (also covers single-channel masks).
   always_comb begin
      logic [AW-1:0] above;
      logic [AW-1:0] lowest;
      logic          found;
      above  = '0;
      lowest = '0;
      found  = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            lowest = AW'(i);
            if (i > int'(active_q)) begin
               above = AW'(i);
               found = 1'b1;
            end
         end
      end
      next_ch = found ? above : lowest;
      wrap    = !found;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      state_n       = state;
      bus.toggle_en = '0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      unique case (state)
         IDLE:  if (start_ok) state_n = FIRE;
         FIRE: begin
            bus.toggle_en = N_CH'(1) << active_q;
            bus.busy      = 1'b1;
            // stop outranks the sweep-complete decision; both end in DONE,
            // but only the non-stopped path may count the sweep (see below).
            if (bus.stop || sweep_end) state_n = DONE;
            else                       state_n = DWELL;
         end
         DWELL: begin
            bus.busy = 1'b1;
            if (bus.stop)                          state_n = DONE;
            else if (dwell_cnt == DWELL_W'(1))     state_n = FIRE;
         end
         DONE: begin
            bus.done = 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Latched configuration, schedule position and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q    <= '0;
         dwell_q   <= '0;
         repeats_q <= '0;
         dwell_cnt <= '0;
         sweep_q   <= '0;
         active_q  <= '0;
      end else begin
         unique case (state)
            IDLE: if (start_ok) begin
               mask_q    <= bus.ch_mask;
               dwell_q   <= bus.dwell;
               repeats_q <= bus.repeats;
               sweep_q   <= '0;
               active_q  <= first_ch;
            end
            FIRE: if (!bus.stop) begin
               // An aborted pulse still fires but never completes a sweep.
               if (wrap) sweep_q <= sweep_inc;
               dwell_cnt <= (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
            end
            DWELL: if (!bus.stop) begin
               dwell_cnt <= dwell_cnt - DWELL_W'(1);
               if (dwell_cnt == DWELL_W'(1)) active_q <= next_ch;
            end
            default: ;
         endcase
      end
   end

   assign bus.active_ch   = active_q;
   assign bus.sweep_count = sweep_q;
endmodule

// File: tb/tb_switch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_switch_sequencer
// Directed scenarios plus randomized runs of switch_sequencer, compared every
// cycle against a schedule model: pulse k of a run lands at 1 + k*(dwell'+1)
// cycles after start, on the (k mod n)-th enabled channel.
// -----------------------------------------------------------------------------
module tb_switch_sequencer;
   localparam int N_CH     = 4;
   localparam int DWELL_W  = 16;
   localparam int REPEAT_W = 8;

   logic clk;
   logic reset;

   switch_sequencer_if #(.N_CH(N_CH), .DWELL_W(DWELL_W), .REPEAT_W(REPEAT_W)) bus ();

   switch_sequencer #(.N_CH(N_CH), .DWELL_W(DWELL_W), .REPEAT_W(REPEAT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Schedule model state.
   bit m_run;          // sequence in progress (busy expected)
   bit m_done;         // done pulse expected this cycle
   int m_t;            // cycles since start was sampled (first pulse at 1)
   int m_p;            // pulse period
   int m_n;            // enabled channel count
   int m_list[N_CH];   // enabled channels, ascending
   int m_total;        // pulses in the run, 0 = unbounded
   int m_counted;      // pulses that completed without abort
   int m_sweep;
   int m_active;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_edge(input bit rst, input bit st, input bit sp,
                             input logic [3:0] mk, input logic [15:0] dw, input logic [7:0] rp);
      bit fire;
      if (rst) begin
         m_run = 0; m_done = 0; m_sweep = 0; m_active = 0;
         return;
      end
      if (m_done) begin
         m_done = 0;
      end else if (!m_run) begin
         if (st && mk != 0) begin
            m_n = 0;
            for (int i = 0; i < N_CH; i++) if (mk[i]) begin m_list[m_n] = i; m_n++; end
            m_p       = ((dw == 0) ? 1 : int'(dw)) + 1;
            m_total   = int'(rp) * m_n;
            m_run     = 1;
            m_t       = 1;
            m_counted = 0;
            m_sweep   = 0;
            m_active  = m_list[0];
         end
      end else begin
         fire = ((m_t - 1) % m_p) == 0;
         if (sp) begin
            m_run  = 0;
            m_done = 1;
         end else begin
            if (fire) begin
               m_counted++;
               m_sweep = (m_counted / m_n) % 256;
            end
            if (m_total != 0 && m_counted == m_total) begin
               m_run  = 0;
               m_done = 1;
            end else begin
               m_t++;
               m_active = m_list[((m_t - 1) / m_p) % m_n];
            end
         end
      end
   endtask

   // One clock: drive inputs at negedge, advance the model, check after posedge.
   task automatic step(input bit rst, input bit st, input bit sp,
                       input logic [3:0] mk, input logic [15:0] dw, input logic [7:0] rp);
      logic [3:0] exp_toggle;
      @(negedge clk);
      reset       = rst;
      bus.start   = st;
      bus.stop    = sp;
      bus.ch_mask = mk;
      bus.dwell   = dw;
      bus.repeats = rp;
      model_edge(rst, st, sp, mk, dw, rp);
      @(posedge clk);
      #1;
      exp_toggle = '0;
      if (m_run && ((m_t - 1) % m_p) == 0) exp_toggle = 4'(1 << m_active);
      check("toggle_en",   32'(bus.toggle_en),   32'(exp_toggle));
      check("busy",        32'(bus.busy),        32'(m_run));
      check("done",        32'(bus.done),        32'(m_done));
      check("active_ch",   32'(bus.active_ch),   32'(m_active));
      check("sweep_count", 32'(bus.sweep_count), 32'(m_sweep));
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++)
         step(0, 0, 0, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 7)), 8'($urandom_range(0, 3)));
   endtask

   initial begin
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.stop    = 1'b0;
      bus.ch_mask = '0;
      bus.dwell   = '0;
      bus.repeats = '0;

      // Reset state.
      step(1, 0, 0, 4'b0000, 16'd0, 8'd0);
      step(1, 1, 0, 4'b1111, 16'd1, 8'd1);

      // Three-channel single sweep: pulses at t1, t5, t9, done at t10.
      step(0, 1, 0, 4'b1011, 16'd3, 8'd1);
      idle(11);

      // Single channel, dwell 0 treated as 1: pulses every 2 cycles, 3 sweeps.
      step(0, 1, 0, 4'b0100, 16'd0, 8'd3);
      idle(7);

      // Continuous run, stop during a dwell.
      step(0, 1, 0, 4'b1111, 16'd2, 8'd0);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 4'b0001, 16'd9, 8'd1);
      step(0, 0, 1, 4'b0001, 16'd9, 8'd1);
      idle(4);

      // Empty mask start is ignored; start during a run is ignored.
      step(0, 1, 0, 4'b0000, 16'd1, 8'd1);
      idle(2);
      step(0, 1, 1, 4'b0011, 16'd4, 8'd2);   // start and stop together in IDLE
      for (int i = 0; i < 5; i++) step(0, 1, 0, 4'b1100, 16'd1, 8'd5);
      idle(18);

      // Reset mid-dwell, then a fresh start.
      step(0, 1, 0, 4'b0011, 16'd5, 8'd0);
      idle(3);
      step(1, 0, 0, 4'b0011, 16'd5, 8'd0);
      idle(1);
      step(0, 1, 0, 4'b0001, 16'd1, 8'd1);
      idle(4);

      // Config changes mid-sequence follow latched values.
      step(0, 1, 0, 4'b1010, 16'd2, 8'd2);
      idle(14);

      // Randomized runs.
      for (int trial = 0; trial < 150; trial++) begin
         step(0, 1, ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
              16'($urandom_range(0, 4)), 8'($urandom_range(0, 3)));
         for (int c = 0; c < 70; c++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 24) == 0) || (c == 60),
                 4'($urandom_range(0, 15)), 16'($urandom_range(0, 4)), 8'($urandom_range(0, 3)));
            if (!m_run && !m_done) break;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
